// File: rtl/avalon_cpt_logger.sv
// Sample logger: valid-only sample stream -> small FIFO -> Avalon-MM master writes into counter RAM.
// Optional LOGGER_TIMESTAMP_EN macro replaces the upper sample half with a free-running cycle stamp.
//
// state | meaning
// IDLE  | armed by START, no samples accepted, master quiet
// RUN   | samples pushed into FIFO, FIFO drained to RAM
// DRAIN | no more samples; FIFO emptied to RAM, then DONE

module avalon_cpt_logger #(
   parameter int FIFO_DEPTH = 4,
   parameter int RAM_WORDS  = 5120
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] sample_data,
   input  logic        sample_valid,
   input  logic [1:0]  s_address,
   input  logic        s_chipselect,
   input  logic        s_read,
   input  logic        s_write,
   input  logic [31:0] s_writedata,
   output logic [31:0] s_readdata,
   output logic [14:0] m_address,
   output logic [3:0]  m_byteenable,
   output logic        m_write,
   output logic [31:0] m_writedata,
   input  logic        m_waitrequest,
   output logic        irq
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [12:0] RAM_W13 = 13'(RAM_WORDS);
   localparam logic [13:0] RAM_W14 = 14'(RAM_WORDS);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t      state;
   logic [12:0] base_q, length_q, base_run, len_run;
   logic        wrap_q, irq_en;
   logic [12:0] index, acc_cnt, wcount;
   logic        done, ovf;

   logic [31:0]   fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] fifo_cnt, fifo_cnt_next;
   logic          fifo_empty, fifo_full;

   logic        busy, pop, push, drop;
   logic        reg_wr, ctrl_wr, status_wr, start_req, stop_req;
   logic [12:0] base_mod, len_eff;
   logic [13:0] word_sum, word;
   logic [31:0] push_word, rd_mux;
   logic        unused_bits;

   assign busy       = (state != IDLE);
   assign fifo_empty = (fifo_cnt == '0);
   assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));

   assign m_write      = busy && !fifo_empty;
   assign m_writedata  = fifo_mem[rd_ptr];
   assign m_byteenable = 4'hF;
   assign irq          = done && irq_en;

   // A full FIFO still accepts a sample when a word leaves in the same cycle.
   assign pop  = m_write && !m_waitrequest;
   assign push = (state == RUN) && sample_valid && (!fifo_full || pop);
   assign drop = (state == RUN) && sample_valid && fifo_full && !pop;
   assign fifo_cnt_next = fifo_cnt + CW'(push) - CW'(pop);

   assign reg_wr    = s_chipselect && s_write;
   assign ctrl_wr   = reg_wr && (s_address == 2'd0);
   assign status_wr = reg_wr && (s_address == 2'd3);
   assign start_req = ctrl_wr && s_writedata[0] && !s_writedata[1] && (state == IDLE);
   assign stop_req  = ctrl_wr && s_writedata[1];

   assign base_mod = (base_q >= RAM_W13) ? base_q - RAM_W13 : base_q;
   assign len_eff  = ((length_q == '0) || (length_q > RAM_W13)) ? RAM_W13 : length_q;
   assign word_sum = {1'b0, base_run} + {1'b0, index};
   assign word     = (word_sum >= RAM_W14) ? word_sum - RAM_W14 : word_sum;
   assign m_address = {word[12:0], 2'b00};

`ifdef LOGGER_TIMESTAMP_EN
   logic [15:0] ts;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ts <= '0;
      else          ts <= ts + 16'd1;
   end

   assign push_word   = {ts, sample_data[15:0]};
   assign unused_bits = ^{s_writedata[31:13], word[13], sample_data[31:16]};
`else
   assign push_word   = sample_data;
   assign unused_bits = ^{s_writedata[31:13], word[13]};
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= push_word;
            wr_ptr <= PW'(wr_ptr + 1'b1);
         end
         if (pop) rd_ptr <= PW'(rd_ptr + 1'b1);
         fifo_cnt <= fifo_cnt_next;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         base_run <= '0;
         len_run  <= '0;
         index    <= '0;
         acc_cnt  <= '0;
         wcount   <= '0;
         done     <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         if (status_wr) begin
            done <= 1'b0;
            ovf  <= 1'b0;
         end
         if (pop) begin
            index <= (index == len_run - 13'd1) ? '0 : index + 13'd1;
            if (wcount != '1) wcount <= wcount + 13'd1;
         end
         case (state)
            IDLE: if (start_req) begin
               state    <= RUN;
               index    <= '0;
               acc_cnt  <= '0;
               wcount   <= '0;
               done     <= 1'b0;
               ovf      <= 1'b0;
               base_run <= base_mod;
               len_run  <= len_eff;
            end
            RUN: begin
               if (push) acc_cnt <= acc_cnt + 13'd1;
               if (drop) ovf <= 1'b1;
               if (stop_req || (push && !wrap_q && (acc_cnt + 13'd1 == len_run)))
                  state <= DRAIN;
            end
            DRAIN: if (fifo_cnt_next == '0) begin
               state <= IDLE;
               done  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      rd_mux = '0;
      case (s_address)
         2'd0:    rd_mux = {28'b0, irq_en, wrap_q, 2'b00};
         2'd1:    rd_mux = {19'b0, base_q};
         2'd2:    rd_mux = {19'b0, length_q};
         default: rd_mux = {3'b0, wcount, 13'b0, ovf, done, busy};
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         base_q     <= '0;
         length_q   <= '0;
         wrap_q     <= 1'b0;
         irq_en     <= 1'b0;
         s_readdata <= '0;
      end else begin
         if (reg_wr) begin
            case (s_address)
               2'd0: begin
                  wrap_q <= s_writedata[2];
                  irq_en <= s_writedata[3];
               end
               2'd1:    base_q   <= s_writedata[12:0];
               2'd2:    length_q <= s_writedata[12:0];
               default: ;
            endcase
         end
         if (s_chipselect && s_read) s_readdata <= rd_mux;
      end
   end

endmodule
